// File: rtl/led_pkg.sv
// Shared LED sweep constants so the sweep counter and the PWM trail agree on pattern width.
package led_pkg;
    localparam int LED_N        = 8;
    localparam int LED_PWM_BITS = 4;
    localparam int LED_MAX      = (1 << LED_PWM_BITS) - 1;
endpackage

// File: rtl/led_trail_pwm_if.sv
// Pattern in / LED drive out between the sweep counter, the trail PWM and the pins.
interface led_trail_pwm_if
    import led_pkg::*;
#(
    parameter int N_LEDS = LED_N
);
    logic              en;
    logic [N_LEDS-1:0] pattern;
    logic [N_LEDS-1:0] led_out;
    logic              onehot_err;

    modport master (output en, output pattern, input led_out, input onehot_err);
    modport slave  (input en, input pattern, output led_out, output onehot_err);
endinterface

// File: rtl/led_trail_pwm_decay_tick.sv
// Decay prescaler: one-cycle tick per DECAY_DIV enabled cycles; combinational from the count.
// No backpressure; en=0 freezes the count and suppresses the tick.
module led_decay_tick #(
    parameter int DECAY_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);
    localparam int PW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DECAY_DIV - 1);

    logic [PW-1:0] pre_cnt_q;
    logic [PW-1:0] pre_cnt_d;

    always_comb begin
        pre_cnt_d = pre_cnt_q;
        tick      = 1'b0;
        if (en) begin
            tick      = (pre_cnt_q == LAST);
            pre_cnt_d = (pre_cnt_q == LAST) ? '0 : pre_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) pre_cnt_q <= '0;
        else       pre_cnt_q <= pre_cnt_d;
    end
endmodule

// File: rtl/led_trail_pwm.sv
// One-hot position to PWM comet tail; pattern to led_out latency is 2 edges.
// No backpressure: pattern sampled every enabled edge, en=0 freezes state and blanks outputs.
module led_trail_pwm
    import led_pkg::*;
#(
    parameter int N_LEDS     = LED_N,
    parameter int PWM_BITS   = LED_PWM_BITS,
    parameter int DECAY_DIV  = 16,
    parameter int DECAY_STEP = 2
) (
    input  logic            clk,
    input  logic            reset,
    led_trail_pwm_if.slave  bus
);
    localparam logic [PWM_BITS-1:0] MAX  = PWM_BITS'((1 << PWM_BITS) - 1);
    localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(DECAY_STEP);

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_d;
    logic [N_LEDS-1:0]   led_out_q;
    logic [N_LEDS-1:0]   led_out_d;
    logic                onehot_err_q;
    logic                onehot_err_d;
    logic                tick;
    logic                is_onehot;

    led_decay_tick #(.DECAY_DIV(DECAY_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (bus.en),
        .tick  (tick)
    );

    // Zero counts as not one-hot; x & (x-1) clears the lowest set bit.
    assign is_onehot = (bus.pattern != '0) &&
                       ((bus.pattern & (bus.pattern - N_LEDS'(1))) == '0);

    always_comb begin
        pwm_cnt_d    = pwm_cnt_q;
        onehot_err_d = onehot_err_q;
        if (bus.en) begin
            pwm_cnt_d    = (pwm_cnt_q == MAX - 1'b1) ? '0 : pwm_cnt_q + 1'b1;
            onehot_err_d = onehot_err_q | ~is_onehot;
        end
    end

    for (genvar i = 0; i < N_LEDS; i++) begin : g_led
        logic [PWM_BITS-1:0] bright_q;
        logic [PWM_BITS-1:0] bright_d;

        // A lit position beats a simultaneous decay tick.
        always_comb begin
            bright_d = bright_q;
            if (bus.en) begin
                if (bus.pattern[i])  bright_d = MAX;
                else if (tick)       bright_d = (bright_q > STEP) ? bright_q - STEP : '0;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) bright_q <= '0;
            else       bright_q <= bright_d;
        end

        assign led_out_d[i] = bus.en & (pwm_cnt_q < bright_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt_q    <= '0;
            led_out_q    <= '0;
            onehot_err_q <= 1'b0;
        end else begin
            pwm_cnt_q    <= pwm_cnt_d;
            led_out_q    <= led_out_d;
            onehot_err_q <= onehot_err_d;
        end
    end

    assign bus.led_out    = led_out_q;
    assign bus.onehot_err = onehot_err_q;
endmodule

// File: tb/tb_led_trail_pwm.sv
// Directed bench for led_trail_pwm at default parameters (8 LEDs, 4-bit PWM, /16, step 2).
module tb_led_trail_pwm;
    logic clk = 1'b0;
    logic reset;
    int   tests_run = 0;
    int   tests_failed = 0;

    led_trail_pwm_if #(.N_LEDS(8)) bus ();

    led_trail_pwm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Brightness of LED0 after m enabled edges since reset, when pattern[0] is
    // held for edges 1..20 and then released: ticks land on edges 16,32,48,...
    function automatic int bright0_exp(int m);
        if (m == 0)   return 0;
        if (m < 32)   return 15;
        if (m >= 144) return 0;
        return 15 - 2 * ((m - 16) / 16);
    endfunction

    task automatic apply_reset(int cycles);
        reset = 1'b1;
        repeat (cycles) step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.en = 1'b1;
        bus.pattern = 8'h01;
        for (int c = 0; c < 3; c++) begin
            step();
            tests_run++;
            if (bus.led_out !== 8'h00 || bus.onehot_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_hold cyc %0d: led_out=%h err=%b, want 00/0", c, bus.led_out, bus.onehot_err);
            end
        end
        reset = 1'b0;
        step();
        tests_run++;
        if (bus.led_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_edge1: led_out=%h want 00", bus.led_out);
        end
        for (int c = 2; c <= 10; c++) begin
            step();
            tests_run++;
            if (bus.led_out !== 8'h01 || bus.onehot_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_relight edge %0d: led_out=%h err=%b, want 01/0", c, bus.led_out, bus.onehot_err);
            end
        end
    endtask

    task automatic test_steady();
        bus.pattern = 8'h04;
        apply_reset(1);
        for (int n = 1; n <= 100; n++) begin
            step();
            tests_run++;
            if (bus.led_out !== ((n >= 2) ? 8'h04 : 8'h00) || bus.onehot_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL steady edge %0d: led_out=%h err=%b, want %h/0", n, bus.led_out,
                         bus.onehot_err, (n >= 2) ? 8'h04 : 8'h00);
            end
        end
    endtask

    task automatic test_decay();
        logic exp0;
        apply_reset(1);
        for (int n = 1; n <= 160; n++) begin
            bus.pattern = (n <= 20) ? 8'h01 : 8'h02;
            step();
            exp0 = ((n - 1) % 15) < bright0_exp(n - 1);
            tests_run++;
            if (bus.led_out[0] !== exp0) begin
                tests_failed++;
                $display("FAIL decay led0 edge %0d: got %b want %b", n, bus.led_out[0], exp0);
            end
            if (n >= 22) begin
                tests_run++;
                if (bus.led_out[1] !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL decay led1 edge %0d: got %b want 1", n, bus.led_out[1]);
                end
            end
        end
    endtask

    task automatic test_onehot_err();
        apply_reset(1);
        bus.pattern = 8'h00;
        step();
        tests_run++;
        if (bus.onehot_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_zero: onehot_err=%b want 1", bus.onehot_err);
        end
        bus.pattern = 8'h03;
        step();
        for (int n = 3; n <= 22; n++) begin
            step();
            tests_run++;
            if (bus.led_out !== 8'h03 || bus.onehot_err !== 1'b1) begin
                tests_failed++;
                $display("FAIL err_multihot edge %0d: led_out=%h err=%b, want 03/1", n, bus.led_out, bus.onehot_err);
            end
        end
        bus.pattern = 8'h01;
        apply_reset(1);
        tests_run++;
        if (bus.onehot_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_clear: onehot_err=%b want 0", bus.onehot_err);
        end
    endtask

    task automatic test_enable_freeze();
        logic exp0;
        apply_reset(1);
        for (int n = 1; n <= 85; n++) begin
            bus.pattern = (n <= 20) ? 8'h01 : 8'h02;
            step();
        end
        // bright0 is 7 here; invalid pattern while disabled must be ignored.
        bus.en = 1'b0;
        bus.pattern = 8'h00;
        for (int c = 0; c < 50; c++) begin
            step();
            tests_run++;
            if (bus.led_out !== 8'h00 || bus.onehot_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL freeze cyc %0d: led_out=%h err=%b, want 00/0", c, bus.led_out, bus.onehot_err);
            end
        end
        bus.en = 1'b1;
        bus.pattern = 8'h02;
        for (int m = 86; m <= 130; m++) begin
            step();
            exp0 = ((m - 1) % 15) < bright0_exp(m - 1);
            tests_run++;
            if (bus.led_out[0] !== exp0 || bus.led_out[1] !== 1'b1) begin
                tests_failed++;
                $display("FAIL resume edge %0d: led0=%b led1=%b, want %b/1", m, bus.led_out[0], bus.led_out[1], exp0);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        apply_reset(1);
        for (int n = 1; n <= 20; n++) begin
            bus.pattern = 8'h01 << ((n - 1) / 5);
            step();
        end
        bus.pattern = 8'h00;
        apply_reset(1);
        tests_run++;
        if (bus.led_out !== 8'h00 || bus.onehot_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset: led_out=%h err=%b, want 00/0", bus.led_out, bus.onehot_err);
        end
        bus.pattern = 8'h10;
        for (int n = 1; n <= 20; n++) begin
            step();
            tests_run++;
            if (bus.led_out !== ((n >= 2) ? 8'h10 : 8'h00)) begin
                tests_failed++;
                $display("FAIL midreset_relight edge %0d: led_out=%h want %h", n, bus.led_out,
                         (n >= 2) ? 8'h10 : 8'h00);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.en = 1'b1;
        bus.pattern = 8'h01;
        test_reset();
        test_steady();
        test_decay();
        test_onehot_err();
        test_enable_freeze();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
